// File: rtl/muldiv_pkg.sv
// Shared funct codes and decode helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mthi;
        logic mflo;
        logic mtlo;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [5:0] opcode, input logic [5:0] funct);
        md_dec_t d;
        logic    rt;
        rt      = (opcode == OP_RTYPE);
        d.mult  = rt && (funct == FN_MULT);
        d.multu = rt && (funct == FN_MULTU);
        d.div   = rt && (funct == FN_DIV);
        d.divu  = rt && (funct == FN_DIVU);
        d.mfhi  = rt && (funct == FN_MFHI);
        d.mthi  = rt && (funct == FN_MTHI);
        d.mflo  = rt && (funct == FN_MFLO);
        d.mtlo  = rt && (funct == FN_MTLO);
        return d;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 datapath: shift-add multiply / restoring divide on unsigned magnitudes.
// acc holds {HI,LO} = {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     sub_diff;

    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        sub_diff  = rem_shift - {1'b0, opnd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
        end else if (start) begin
            // op_a is multiplicand / dividend, op_b multiplier / divisor
            acc  <= {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
            opnd <= is_div ? op_b : op_a;
        end else if (step) begin
            if (is_div) begin
                if (!sub_diff[WIDTH])
                    acc <= {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc <= {add_sum, acc[WIDTH-1:1]};
            end
        end
    end

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: WIDTH iteration cycles plus one sign-fix cycle.
// Stalls any mult/div/mf/mt instruction while an operation is in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam int         CW      = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             op_div, neg_lo, neg_hi, div_zero;

    md_dec_t          dec;
    logic             md_op, accept, start, signed_op, start_div;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    always_comb begin
        dec       = md_decode(opcode, funct);
        md_op     = valid && (|dec);
        busy      = (state != ST_IDLE);
        stall     = md_op && busy;
        accept    = md_op && !busy;
        start     = accept && (dec.mult || dec.multu || dec.div || dec.divu);
        start_div = dec.div || dec.divu;
        signed_op = dec.mult || dec.div;
        rs_neg    = signed_op && rs_val[WIDTH-1];
        rt_neg    = signed_op && rt_val[WIDTH-1];
        rs_mag    = rs_neg ? -rs_val : rs_val;
        rt_mag    = rt_neg ? -rt_val : rt_val;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .step   (state == ST_ITER),
        .is_div (busy ? op_div : start_div),
        .op_a   (rs_mag),
        .op_b   (rt_mag),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state    <= ST_ITER;
                    count    <= CW'(WIDTH);
                    op_div   <= start_div;
                    neg_lo   <= rs_neg ^ rt_neg;
                    // remainder follows the dividend; a product is negated as a whole
                    neg_hi   <= start_div ? rs_neg : (rs_neg ^ rt_neg);
                    div_zero <= start_div && (rt_val == '0);
                end
                ST_ITER: begin
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= ST_FIX;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Divide by zero leaves |rs| in the remainder, so re-signing it restores rs unmodified.
    always_comb begin
        prod_fix = neg_lo ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
        quot_fix = div_zero ? {WIDTH{1'b1}} : (neg_lo ? -iter_lo : iter_lo);
        rem_fix  = neg_hi ? -iter_hi : iter_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == ST_FIX) begin
            hi_reg <= op_div ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= op_div ? quot_fix : prod_fix[WIDTH-1:0];
        end else if (accept) begin
            if (dec.mthi) hi_reg <= rs_val;
            if (dec.mtlo) lo_reg <= rs_val;
        end
    end

    always_comb begin
        result = '0;
        if (accept && dec.mfhi)
            result = hi_reg;
        else if (accept && dec.mflo)
            result = lo_reg;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS150 execute stage. Decodes RTYPE MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from opcode/funct, runs a radix-2 shift-add or restoring-divide datapath over WIDTH cycles, and stalls the pipeline on HI/LO hazards. Sits beside the ALU; its result is muxed into the writeback path for MFHI/MFLO.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid  in  1  execute-stage instruction is valid and not squashed
- opcode  in  6  instruction bits [31:26]
- funct  in  6  instruction bits [5:0]
- rs_val  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  WIDTH  rt operand (divisor / multiplier)
- stall  out  1  combinational; hold the execute stage this cycle
- result  out  WIDTH  combinational; HI for MFHI, LO for MFLO, else 0
- busy  out  1  registered; operation in flight

## Operation

- Decode only when opcode == RTYPE: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other funct/opcode: unit ignores it, stall=0, result=0.
- md_op = valid & decoded as any of the eight above.
- stall = md_op & busy. Accept = md_op & ~busy.
- FSM states: IDLE, ITER, FIX.
  - IDLE: accept of MULT/MULTU/DIV/DIVU captures |rs|,|rt| (magnitudes for signed ops, raw for unsigned), sign flags, op kind; counter <= WIDTH; -> ITER.
  - ITER: one shift-add (mul) or shift-subtract-restore (div) step per cycle; counter decrements; at counter==1 -> FIX.
  - FIX: apply sign correction, write HI/LO; -> IDLE.
- Multiply: 2*WIDTH product; HI = upper, LO = lower; signed product negated if sign(rs)!=sign(rt).
- Divide: LO = quotient, HI = remainder. Signed: quotient negative iff signs differ; remainder takes dividend's sign. Truncation toward zero.
- Divide by zero (rt==0, signed or unsigned): LO = all ones, HI = rs_val unmodified. Same latency.
- Signed overflow (rs = 100..0, rt = all ones): LO = 100..0, HI = 0.
- MTHI/MTLO accepted in IDLE: write HI/LO at the accepting edge; no busy cycles.
- MFHI/MFLO accepted in IDLE: result = current HI/LO register value combinationally.
- busy = (state != IDLE).
- Reset (any state, mid-operation included): state IDLE, HI=LO=0, counter=0, busy=0; in-flight op discarded.

## Timing

- MULT/DIV accepted at edge of cycle 0; ITER occupies cycles 1..WIDTH; FIX cycle WIDTH+1; HI/LO valid and busy=0 from cycle WIDTH+2 (WIDTH+2 cycles total, 34 for WIDTH=32).
- busy rises the cycle after accept, falls the cycle after FIX.
- MFHI/MFLO in the FIX cycle stalls; in cycle WIDTH+2 returns new value.
- Back-to-back MULT while busy: stalled until IDLE, then accepted the same cycle busy reads 0.
- MTHI followed by MFHI next cycle sees the new value (register write-then-read, no bypass needed).
- result and stall are purely combinational from inputs and registered state; no output register.

## Structure

- Funct codes MULT..MTLO added to shared Opcode.vh alongside existing RTYPE funct defines; FSM state encodings as localparams in the module.
- One sub-module natural: muldiv_iter — datapath holding the 2*WIDTH accumulator/remainder shift register and per-step add/subtract, controlled by muldiv_unit's FSM (start, step, is_div).
- Sign capture and FIX-stage negation stay in muldiv_unit.

## Test plan

- MULTU rs=0xFFFFFFFF rt=2 -> busy 33 cycles; cycle 34 HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=-3 rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=0x1234 rt=0 -> LO=0xFFFFFFFF, HI=0x00001234; DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT then MFLO next cycle -> stall=1 for cycles 1..33, cycle 34 stall=0 and result=product LO; MFLO with valid=0 -> stall=0.
- MTLO rs=0xCAFEF00D then MFLO next cycle -> result=0xCAFEF00D, busy never asserted; non-muldiv funct (ADDU) -> stall=0, result=0.
- Assert rst_n=0 in cycle 10 of a DIV -> busy=0, HI=LO=0 immediately; after release, new MULTU 6*7 -> LO=42, HI=0.
